aes_inv_key_sched: RTL and testbench
====================================

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
Parameters: none; AES-128 only (Nk=4, Nr=10).
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  pulse requesting a new schedule; accepted only in IDLE.
REQ-005 key_i  input  128  last-round key (round 10); FIPS-197 byte order: bits 127:120 = byte 0, word w0 = bits 127:96.
REQ-006 abort  input  1  synchronous cancel of the current schedule.
REQ-007 rk_ready  input  1  consumer accepts rk_o this cycle.
REQ-008 rk_valid  output  1  rk_o and rk_idx are valid.
REQ-009 rk_o  output  128  round key in the same byte order as key_i.
REQ-010 rk_idx  output  4  round number of rk_o, 10 down to 0.
REQ-011 busy  output  1  high whenever the block is not in IDLE.
REQ-012 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-013 The FSM SHALL have three states: IDLE, EMIT and FIN.
REQ-014 IDLE with start=1: register key_i into the key register, set rk_idx=10, go to EMIT; rk_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-015 In EMIT: rk_valid=1, and rk_o/rk_idx SHALL hold stable while rk_ready=0.
REQ-016 In EMIT, when rk_valid&rk_ready and rk_idx>0: the key register SHALL load the inverse step of the current key, and rk_idx SHALL decrement, on that clock edge.
REQ-017 Inverse step, current words w0..w3, round i=rk_idx: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{Rcon[i],24'h0}.
REQ-018 RotWord({a,b,c,d})={b,c,d,a}; SubWord applies the forward AES S-box to each byte; Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36.
REQ-019 In EMIT, when rk_valid&rk_ready and rk_idx=0: go to FIN; rk_valid SHALL be 0 on the next cycle.
REQ-020 In FIN, done=1 for exactly one cycle, then go to IDLE; busy=1 in EMIT and FIN.
REQ-021 start while busy SHALL be ignored, with no change to key, index or state.
REQ-022 abort=1 in any state SHALL go to IDLE on the next edge with rk_valid=0 and done=0; abort SHALL take priority over start and over the rk_ready handshake in the same cycle.
REQ-023 A start in the IDLE cycle that directly follows FIN SHALL be accepted (back-to-back schedules).
REQ-024 Exactly 11 beats SHALL be emitted per schedule, with no skipped or repeated rk_idx value.
REQ-025 The S-box and step logic SHALL be combinational from the key register; there SHALL be one step per accepted beat and no multi-cycle compute.

Reset
REQ-026 While rst_n=0, all outputs SHALL be: state=IDLE, rk_valid=0, done=0, busy=0, rk_idx=0, rk_o=128'h0.
REQ-027 Reset asserted mid-schedule SHALL abandon the schedule immediately and asynchronously.
REQ-028 After reset release, the first start SHALL behave per REQ-014.

Verification
REQ-029 FIPS-197 A.1, rk_ready held at 1: start with key_i=d014f9a8c9ee2589e13f0cc8b6630ca6 -> idx10=d014f9a8c9ee2589e13f0cc8b6630ca6, idx9=ac7766f319fadc2128d12941575c006e, ..., idx0=2b7e151628aed2a6abf7158809cf4f3c; done pulses 1 cycle after idx0; 11 beats in 11 consecutive cycles.
REQ-030 Backpressure: rk_ready random at 50% -> the beat sequence is identical to REQ-029; rk_o/rk_idx stable while rk_valid&!rk_ready.
REQ-031 start pulsed while at idx 5 -> ignored; the sequence completes unchanged.
REQ-032 abort at idx 7 with rk_ready=1 -> next cycle rk_valid=0, busy=0, no done; a new start then produces a full 11-beat sequence.
REQ-033 rst_n dropped at idx 3 -> outputs immediately match REQ-026; after release, start with the all-zero-expansion round-10 key b4ef5bcb3e92e21123e951cf6f8f188e -> idx0=128'h0.
REQ-034 Back-to-back: start in the first IDLE cycle after done -> accepted; rk_valid returns the following cycle with idx 10.

Source files
------------

// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between a round-key consumer and the inverse AES-128 key
// scheduler. The scheduler takes the slave side; whoever drives start and
// consumes round keys takes the master side.
interface aes_inv_key_sched_if;
    logic         start;
    logic [127:0] key_i;
    logic         abort;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    modport master (
        output start, key_i, abort, rk_ready,
        input  rk_valid, rk_o, rk_idx, busy, done
    );

    modport slave (
        input  start, key_i, abort, rk_ready,
        output rk_valid, rk_o, rk_idx, busy, done
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule. Starting from the round-10 key it walks
// backwards one round per accepted beat, presenting round keys 10 down to 0
// on a valid/ready stream. The backwards step is purely combinational from
// the key register, so every accepted beat costs exactly one clock.
module aes_inv_key_sched (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_key_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Forward AES S-box, row-major; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t        state_q;
    state_t        state_d;
    logic [127:0]  key_q;
    logic [127:0]  key_d;
    logic [3:0]    idx_q;
    logic [3:0]    idx_d;
    logic [127:0]  step_key;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round i of the forward expansion used Rcon[i]; undoing round i needs it too.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Undo one expansion round: recover w1..w3 by XOR chaining, then strip the
    // g() term from w0 using the recovered previous-round w3.
    always_comb begin
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(idx_q), 24'h0};
        step_key = {p0, p1, p2, p3};
    end

    // Next-state logic: abort wins over everything, start only counts in IDLE,
    // and the key advances only on an accepted beat that is not the last one.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        key_d   = bus.key_i;
                        idx_d   = 4'd10;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (bus.rk_ready) begin
                        if (idx_q != 4'd0) begin
                            key_d = step_key;
                            idx_d = idx_q - 4'd1;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, key and round index registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.rk_valid = (state_q == EMIT);
    assign bus.rk_o     = key_q;
    assign bus.rk_idx   = idx_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FIN);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for the inverse AES-128 key scheduler: FIPS-197 A.1 round
// keys in reverse, backpressure, ignored start, abort, mid-schedule reset,
// and back-to-back schedules.
module tb_aes_inv_key_sched;

    localparam logic [127:0] KEY_A1     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    beat_t exp_tbl[11];
    int n_vec = 0;
    int n_bad = 0;

    aes_inv_key_sched_if bus ();

    aes_inv_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop if something wedges despite the per-wait bounds.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic [127:0] key, input logic rdy, input logic ab);
        bus.start    = st;
        bus.key_i    = key;
        bus.rk_ready = rdy;
        bus.abort    = ab;
    endtask

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_valid"}, {127'd0, bus.rk_valid}, 128'd0);
        check_output({tag, "_done"},  {127'd0, bus.done},     128'd0);
        check_output({tag, "_busy"},  {127'd0, bus.busy},     128'd0);
    endtask

    task automatic issue_start(input logic [127:0] key);
        apply_stimulus(1'b1, key, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, junk(), 1'b0, 1'b0);
    endtask

    // Accept beats at full rate until the target round key is on the bus, then hold.
    task automatic advance_to(input logic [3:0] target);
        int c = 0;
        while (!(bus.rk_valid && bus.rk_idx == target) && c < 50) begin
            apply_stimulus(1'b0, junk(), 1'b1, 1'b0);
            @(negedge clk);
            c++;
        end
        apply_stimulus(1'b0, junk(), 1'b0, 1'b0);
        check_output("reach_valid", {127'd0, bus.rk_valid}, 128'd1);
        check_output("reach_idx", {124'd0, bus.rk_idx}, {124'd0, target});
    endtask

    // Consume one whole schedule starting in EMIT; ends on the first IDLE cycle
    // after done. With use_tbl=0 only the first and last keys are known.
    task automatic run_schedule(input int ready_pct, input int poke_idx, input bit use_tbl);
        int beat = 0;
        int cycles = 0;
        logic stalled = 1'b0;
        logic [3:0] prev_idx = '0;
        logic [127:0] prev_rk = '0;
        logic rdy;
        while (beat < 11 && cycles < 300) begin
            check_output("beat_valid", {127'd0, bus.rk_valid}, 128'd1);
            check_output("beat_idx", {124'd0, bus.rk_idx}, {124'd0, exp_tbl[beat].idx});
            if (use_tbl)
                check_output("beat_rk", bus.rk_o, exp_tbl[beat].rk);
            else if (beat == 0)
                check_output("beat_rk_first", bus.rk_o, KEY_ZERO10);
            else if (beat == 10)
                check_output("beat_rk_last", bus.rk_o, 128'h0);
            if (stalled) begin
                check_output("hold_idx", {124'd0, bus.rk_idx}, {124'd0, prev_idx});
                check_output("hold_rk", bus.rk_o, prev_rk);
            end
            rdy = ($urandom_range(99) < ready_pct);
            apply_stimulus((poke_idx >= 0) && (int'(bus.rk_idx) == poke_idx), junk(), rdy, 1'b0);
            prev_idx = bus.rk_idx;
            prev_rk  = bus.rk_o;
            stalled  = !rdy;
            if (rdy)
                beat++;
            @(negedge clk);
            cycles++;
        end
        apply_stimulus(1'b0, junk(), 1'b0, 1'b0);
        check_output("beat_count", beat, 11);
        if (ready_pct >= 100)
            check_output("beat_cycles", cycles, 11);
        check_output("fin_valid", {127'd0, bus.rk_valid}, 128'd0);
        check_output("fin_done", {127'd0, bus.done}, 128'd1);
        check_output("fin_busy", {127'd0, bus.busy}, 128'd1);
        @(negedge clk);
        check_idle_outputs("post_fin");
    endtask

    initial begin
        exp_tbl[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        exp_tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        exp_tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        exp_tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        exp_tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        exp_tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        exp_tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        exp_tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        exp_tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        exp_tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        exp_tbl[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        apply_stimulus(1'b0, 128'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_output("reset_idx", {124'd0, bus.rk_idx}, 128'd0);
        check_output("reset_rk", bus.rk_o, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 at full rate, then a back-to-back start with backpressure
        // and a stray start while round key 5 is presented.
        issue_start(KEY_A1);
        run_schedule(100, -1, 1'b1);
        issue_start(KEY_A1);
        run_schedule(50, 5, 1'b1);

        // Abort at round 7 together with ready and start: abort must win.
        @(negedge clk);
        issue_start(KEY_A1);
        advance_to(4'd7);
        apply_stimulus(1'b1, junk(), 1'b1, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, junk(), 1'b0, 1'b0);
        check_idle_outputs("abort");
        @(negedge clk);
        check_idle_outputs("abort_after");
        issue_start(KEY_A1);
        run_schedule(100, -1, 1'b1);

        // Reset dropped mid-cycle at round 3; outputs must clear before any edge.
        issue_start(KEY_A1);
        advance_to(4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check_output("async_rst_idx", {124'd0, bus.rk_idx}, 128'd0);
        check_output("async_rst_rk", bus.rk_o, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_start(KEY_ZERO10);
        run_schedule(100, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
